mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Multi-cycle controller between the decoder's memory controls (MemRead/MemWrite/MemNum/UnSigned)
//  and a byte-wide data memory port. Splits word/half/byte loads and stores into sequential
//  big-endian byte transfers, sign/zero-extends loads, and stalls the PC/pipeline while busy.
//  Flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT  255  max cycles waiting for mem_ack_i per byte; 0 = wait forever
//  CNT_W    8    width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous reset, active high
//  req_i        in   1   current instruction requests a memory access (level)
//  MemRead_i    in   1   load
//  MemWrite_i   in   1   store
//  MemNum_i     in   2   access size: 01 = byte, 10 = half, 11 = word, 00 = none
//  UnSigned_i   in   1   load zero-extends when 1, sign-extends when 0
//  addr_i       in   32  effective byte address (ALU result)
//  wdata_i      in   32  store data; low N bytes are used
//  rdata_o      out  32  load result; valid while done_o = 1
//  stall_o      out  1   hold PC/pipeline
//  done_o       out  1   1-cycle pulse: access finished (ok or error)
//  err_o        out  1   1-cycle pulse with done_o: misaligned, illegal or timeout
//  mem_req_o    out  1   byte transfer request
//  mem_we_o     out  1   1 = write byte, 0 = read byte
//  mem_addr_o   out  32  byte address
//  mem_wdata_o  out  8   write byte
//  mem_rdata_i  in   8   read byte; sampled when mem_ack_i = 1
//  mem_ack_i    in   1   transfer complete this cycle
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; rdata_o = 0; internal counters cleared.
//  N = 1/2/4 for MemNum 01/10/11.
//  Start condition: req_i & (MemRead_i | MemWrite_i) & MemNum_i != 0.
//  FSM states:
//   IDLE:
//    - Start condition met: latch op, N, UnSigned, addr, wdata; stall_o = 1 combinationally in that cycle.
//    - Error if addr[0] != 0 for half, addr[1:0] != 0 for word, or MemRead_i & MemWrite_i both set.
//    - On error -> DONE with err. Otherwise -> XFER with byte counter k = 0 and timeout counter = 0.
//    - req_i with MemNum_i = 00, or with neither MemRead_i nor MemWrite_i: ignored, no stall.
//   XFER:
//    - Drives mem_req_o = 1, mem_addr_o = addr + k, mem_we_o = store.
//    - mem_wdata_o = wdata[8*(N-1-k)+7 -: 8] (big-endian: lowest address holds the MSB).
//    - On mem_ack_i: a load writes mem_rdata_i into byte (N-1-k) of the assembly register.
//      If k == N-1 -> DONE, else k += 1 and the timeout counter clears.
//    - No ack for TIMEOUT consecutive cycles (TIMEOUT != 0) -> DONE with err; mem_req_o drops.
//    - stall_o = 1 throughout.
//   DONE:
//    - done_o = 1 and err_o = error flag for exactly 1 cycle; stall_o = 0; -> IDLE.
//    - Load OK: rdata_o = extend(low 8*N assembled bits); sign bit is bit 8N-1.
//    - Store, or any error: rdata_o = 0.
//  rdata_o holds its value after DONE until the next DONE or reset.
//  Latency with ack in the same cycle as req: N+2 cycles from start to done_o; stall_o high N+1 cycles.
//  Error path: done_o 1 cycle after start; no mem_req_o is ever issued.
//  Input changes during XFER/DONE are ignored; the latched copy is used.
//  Reset mid-XFER: mem_req_o drops immediately; partial data is discarded; no done_o.
//  mem_ack_i outside XFER: ignored.
// TESTING
//  - LW addr 0x100, mem[0x100..0x103] = 12 34 56 78, ack every cycle
//    -> 4 reads at 0x100..0x103; rdata_o = 0x12345678; done at cycle 6; stall 5 cycles.
//  - LB addr 0x7 with byte 0x80, UnSigned = 0 -> rdata_o = 0xFFFFFF80.
//    Same access with LBU -> rdata_o = 0x00000080.
//  - SH addr 0x22, wdata = 0xAAAABEEF -> writes 0xBE @0x22 then 0xEF @0x23; rdata_o = 0; err_o = 0.
//  - LW addr 0x101 -> no mem_req_o; done_o and err_o pulse 1 cycle after start.
//    SH addr 0x3 -> same response.
//  - TIMEOUT = 4, ack never asserted -> mem_req_o high 4 cycles, then done_o + err_o pulse.
//  - rst_i asserted during byte 2 of a LW -> mem_req_o = 0 immediately, state IDLE, no done_o.
//    A new SB after reset completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Breaks word/half/byte loads and stores into big-endian byte transfers on a
// byte-wide memory port. The lowest address carries the most significant byte.
// Loads are sign- or zero-extended. The pipeline is held while an access is in flight.
// Misaligned accesses, read+write requests and transfers with no ack are reported
// through err_o.
module mem_access_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  MemNum_i,
  input  logic        UnSigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last value the wait counter reaches before the access is abandoned.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic             we_q;
  logic             uns_q;
  logic [2:0]       n_q;
  logic [1:0]       k_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      asm_q;
  logic [CNT_W-1:0] tcnt_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic             start_d;
  logic             bad_d;
  logic [2:0]       n_d;
  logic             last_d;
  logic             timeout_d;
  logic [1:0]       idx_d;
  logic [31:0]      asm_d;
  logic             xfer_d;

  // Extend the low 8*N assembled bits to a full word.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] n,
                                         input logic uns);
    logic [31:0] r;
    case (n)
      3'd1:    r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      3'd2:    r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      3'd4:    r = v;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Decode the request: start condition, byte count and illegal/misaligned check.
  always_comb begin
    start_d = req_i & (MemRead_i | MemWrite_i) & (MemNum_i != 2'b00);
    case (MemNum_i)
      2'b01:   n_d = 3'd1;
      2'b10:   n_d = 3'd2;
      2'b11:   n_d = 3'd4;
      default: n_d = 3'd0;
    endcase
    bad_d = ((MemNum_i == 2'b10) & addr_i[0])
          | ((MemNum_i == 2'b11) & (addr_i[1:0] != 2'b00))
          | (MemRead_i & MemWrite_i);
  end

  // Position of the current byte inside the word and the assembly register with it merged in.
  always_comb begin
    idx_d     = 2'(n_q - 3'd1 - {1'b0, k_q});
    last_d    = ({1'b0, k_q} == (n_q - 3'd1));
    timeout_d = (TIMEOUT != 0) && (tcnt_q == TO_LAST);
    xfer_d    = (state_q == XFER);
    asm_d     = asm_q;
    asm_d[{idx_d, 3'b000} +: 8] = mem_rdata_i;
  end

  // Sequencer FSM: latch the request, walk the bytes, and pulse done/err for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      n_q     <= 3'd0;
      k_q     <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            we_q    <= MemWrite_i;
            uns_q   <= UnSigned_i;
            n_q     <= n_d;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            k_q     <= 2'd0;
            tcnt_q  <= '0;
            asm_q   <= 32'd0;
            if (bad_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q <= XFER;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        XFER: begin
          if (mem_ack_i) begin
            if (!we_q) begin
              asm_q <= asm_d;
            end else begin
              asm_q <= asm_q;
            end
            if (last_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rdata_q <= we_q ? 32'd0 : extend(asm_d, n_q, uns_q);
            end else begin
              k_q    <= k_q + 2'd1;
              tcnt_q <= '0;
            end
          end else if (timeout_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end else begin
            tcnt_q <= tcnt_q + CNT_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory port and stall are decoded from the registered state and the latched request.
  always_comb begin
    mem_req_o   = xfer_d;
    mem_we_o    = xfer_d & we_q;
    mem_addr_o  = xfer_d ? (addr_q + {30'd0, k_q}) : 32'd0;
    mem_wdata_o = (xfer_d & we_q) ? wdata_q[{idx_d, 3'b000} +: 8] : 8'd0;
    stall_o     = xfer_d | ((state_q == IDLE) & start_d);
    done_o      = done_q;
    err_o       = err_q;
    rdata_o     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small byte memory model.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, mrd, mwr, uns;
  logic [1:0]  mnum;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, err;
  logic        mreq, mwe;
  logic [31:0] maddr;
  logic [7:0]  mwdata, mrdata;
  logic        mack;
  logic        ack_en;

  logic [7:0]  mem [0:511];
  int          vectors = 0;
  int          miscompares = 0;
  int          req_cycles;
  int          nwr;
  logic [31:0] wr_addr [0:7];
  logic [7:0]  wr_data [0:7];
  logic [31:0] rd_addr [0:7];
  int          nrd;

  int          dcyc, scnt;
  logic        derr;
  logic [31:0] drd;

  mem_access_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .MemRead_i(mrd), .MemWrite_i(mwr),
    .MemNum_i(mnum), .UnSigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .stall_o(stall), .done_o(done), .err_o(err),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_rdata_i(mrdata), .mem_ack_i(mack)
  );

  always #5 clk = ~clk;

  assign mack   = mreq & ack_en;
  assign mrdata = mem[maddr[8:0]];

  // Memory model: log every transfer and apply writes.
  always @(posedge clk) begin
    if (mreq) req_cycles <= req_cycles + 1;
    if (mreq && mack) begin
      if (mwe) begin
        mem[maddr[8:0]] <= mwdata;
        if (nwr < 8) begin
          wr_addr[nwr] <= maddr;
          wr_data[nwr] <= mwdata;
        end
        nwr <= nwr + 1;
      end else begin
        if (nrd < 8) rd_addr[nrd] <= maddr;
        nrd <= nrd + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    req_cycles = 0;
    nwr = 0;
    nrd = 0;
  endtask

  // Issue one access and watch until done_o (bounded), returning latency, stall count and result.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] num,
                            input logic u, input logic [31:0] a, input logic [31:0] wd);
    int cyc;
    logic got;
    clear_log();
    req = 1'b1; mrd = rd; mwr = wr; mnum = num; uns = u; addr = a; wdata = wd;
    cyc = 1; scnt = 0; dcyc = 0; derr = 1'b0; drd = 32'd0; got = 1'b0;
    while (cyc <= 30 && !got) begin
      #1;
      if (stall) scnt++;
      if (done) begin
        got = 1'b1; dcyc = cyc; derr = err; drd = rdata;
      end else begin
        @(posedge clk);
        #1;
        req = 1'b0; mrd = 1'b0; mwr = 1'b0; mnum = 2'b00; addr = 32'hDEAD_BEEF; wdata = 32'h0;
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h100] = 8'h12; mem[9'h101] = 8'h34; mem[9'h102] = 8'h56; mem[9'h103] = 8'h78;
    mem[9'h007] = 8'h80;
    req = 0; mrd = 0; mwr = 0; mnum = 0; uns = 0; addr = 0; wdata = 0; ack_en = 1'b1;
    req_cycles = 0; nwr = 0; nrd = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_mreq", {31'd0, mreq}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // LW 0x100
    run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    check_val("lw_done_cyc", dcyc, 32'd6);
    check_val("lw_stall", scnt, 32'd5);
    check_val("lw_rdata", drd, 32'h12345678);
    check_val("lw_err", {31'd0, derr}, 32'd0);
    check_val("lw_nrd", nrd, 32'd4);
    for (int i = 0; i < 4; i++) check_val("lw_raddr", rd_addr[i], 32'h100 + i);
    @(negedge clk); #1;
    check_val("lw_hold", rdata, 32'h12345678);
    check_val("lw_done_pulse", {31'd0, done}, 32'd0);

    // LB / LBU 0x7
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h7, 32'h0);
    check_val("lb_rdata", drd, 32'hFFFFFF80);
    check_val("lb_done_cyc", dcyc, 32'd3);
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h7, 32'h0);
    check_val("lbu_rdata", drd, 32'h00000080);

    // SH 0x22
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hAAAABEEF);
    check_val("sh_rdata", drd, 32'd0);
    check_val("sh_err", {31'd0, derr}, 32'd0);
    check_val("sh_nwr", nwr, 32'd2);
    check_val("sh_a0", wr_addr[0], 32'h22);
    check_val("sh_d0", {24'd0, wr_data[0]}, 32'hBE);
    check_val("sh_a1", wr_addr[1], 32'h23);
    check_val("sh_d1", {24'd0, wr_data[1]}, 32'hEF);

    // LH 0x22 reads the halfword back, sign-extended
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    check_val("lh_rdata", drd, 32'hFFFFBEEF);

    // Misaligned and illegal
    run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h101, 32'h0);
    check_val("lw_mis_cyc", dcyc, 32'd2);
    check_val("lw_mis_err", {31'd0, derr}, 32'd1);
    check_val("lw_mis_req", req_cycles, 32'd0);
    check_val("lw_mis_rdata", drd, 32'd0);
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h3, 32'h1234);
    check_val("sh_mis_cyc", dcyc, 32'd2);
    check_val("sh_mis_err", {31'd0, derr}, 32'd1);
    check_val("sh_mis_req", req_cycles, 32'd0);
    run_access(1'b1, 1'b1, 2'b01, 1'b0, 32'h4, 32'h0);
    check_val("rw_err", {31'd0, derr}, 32'd1);

    // Ignored request: size 00
    clear_log();
    req = 1'b1; mrd = 1'b1; mwr = 1'b0; mnum = 2'b00; addr = 32'h100;
    #1;
    check_val("ign_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("ign_req", req_cycles, 32'd0);
    check_val("ign_done", {31'd0, done}, 32'd0);
    req = 1'b0; mrd = 1'b0;

    // Timeout
    ack_en = 1'b0;
    run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    check_val("to_req_cycles", req_cycles, 32'd4);
    check_val("to_err", {31'd0, derr}, 32'd1);
    check_val("to_done_cyc", dcyc, 32'd6);
    check_val("to_rdata", drd, 32'd0);
    ack_en = 1'b1;

    // Reset during byte 2 of LW
    clear_log();
    req = 1'b1; mrd = 1'b1; mwr = 1'b0; mnum = 2'b11; uns = 1'b0; addr = 32'h100;
    @(posedge clk); #1;
    req = 1'b0; mrd = 1'b0; mnum = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_mid_mreq_before", {31'd0, mreq}, 32'd1);
    check_val("rst_mid_addr", maddr, 32'h101);
    rst = 1'b1;
    #1;
    check_val("rst_mid_mreq", {31'd0, mreq}, 32'd0);
    check_val("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done || mreq) seen++;
      end
      check_val("rst_mid_quiet", seen, 32'd0);
    end

    // SB after reset
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000005A);
    check_val("sb_cyc", dcyc, 32'd3);
    check_val("sb_err", {31'd0, derr}, 32'd0);
    check_val("sb_mem", {24'd0, mem[9'h040]}, 32'h5A);
    check_val("sb_nwr", nwr, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
